// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a first-word-fall-through byte FIFO.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   rxd            - asynchronous serial input (idle high)
//   out_data       - FIFO head byte, meaningful while out_valid is high
//   out_valid      - FIFO non-empty
//   out_ready      - consumer pops the head when out_valid && out_ready
//   level          - FIFO occupancy 0..FIFO_DEPTH
//   frame_err      - sticky: stop bit sampled low
//   overrun        - sticky: good byte dropped because the FIFO was full
//   clr_err        - clears both sticky flags (a coincident set wins)
//   busy           - receiver not idle
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned LEVEL_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rxd,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level,
  output logic               frame_err,
  output logic               overrun,
  input  logic               clr_err,
  output logic               busy
);

  localparam int unsigned AW = LEVEL_W - 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]      HALF_BIT = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0]      FULL_BIT = TW'(CLKS_PER_BIT);
  localparam logic [LEVEL_W-1:0] DEPTH    = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state;
  logic               sync1;
  logic               rxs;
  logic [TW-1:0]      timer;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [LEVEL_W-1:0] wptr;
  logic [LEVEL_W-1:0] rptr;

  logic               expire_c;
  logic               stop_good_c;
  logic               stop_bad_c;
  logic               pop_c;
  logic               wr_c;
  logic               drop_c;
  logic [LEVEL_W-1:0] wptr_nxt_c;
  logic [LEVEL_W-1:0] rptr_nxt_c;

  // Timer holds the number of cycles left including the current one; 1 means sample now.
  assign expire_c    = (timer == TW'(1));
  assign stop_good_c = (state == S_STOP) && expire_c && rxs;
  assign stop_bad_c  = (state == S_STOP) && expire_c && !rxs;
  assign pop_c       = out_valid && out_ready;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign wr_c        = stop_good_c && ((level != DEPTH) || pop_c);
  assign drop_c      = stop_good_c && (level == DEPTH) && !pop_c;
  assign wptr_nxt_c  = wptr + LEVEL_W'(wr_c);
  assign rptr_nxt_c  = rptr + LEVEL_W'(pop_c);

  assign out_data    = out_valid ? mem[rptr[AW-1:0]] : 8'h00;

  // Two-flop synchroniser for the asynchronous serial pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  // Receiver FSM: mid-bit sampling with a reloading bit timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            timer <= HALF_BIT;
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (expire_c) begin
            if (rxs) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              timer   <= FULL_BIT;
              bit_idx <= '0;
              state   <= S_DATA;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DATA: begin
          if (expire_c) begin
            shift   <= {rxs, shift[7:1]};
            timer   <= FULL_BIT;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_STOP: begin
          if (expire_c) begin
            if (rxs) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_BREAK;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_BREAK: begin
          // Held-low line must return high before a new start bit is accepted.
          if (rxs) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage and pointers; level/out_valid track the pointers on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_c) begin
        mem[wptr[AW-1:0]] <= shift;
      end
      wptr      <= wptr_nxt_c;
      rptr      <= rptr_nxt_c;
      level     <= wptr_nxt_c - rptr_nxt_c;
      out_valid <= (wptr_nxt_c != rptr_nxt_c);
    end
  end

  // Sticky error flags; a new event overrides a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (stop_bad_c) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: bench for uart_rx_fifo at 16 clocks/bit and a 4-entry FIFO.
// A schedule-based receiver model and a byte queue predict every output each cycle.
module tb_uart_rx_fifo;

  localparam int C = 16;
  localparam int H = C / 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  uart_rx_fifo #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D),
    .LEVEL_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .frame_err(frame_err),
    .overrun  (overrun),
    .clr_err  (clr_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int last_k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          s1 = 1'b1;
  bit          s2 = 1'b1;
  byte unsigned q[$];
  bit          m_ferr = 1'b0;
  bit          m_ovr  = 1'b0;
  int          mode   = 0;      // 0 idle, 1 receiving, 2 waiting for line high
  int          t0     = 0;
  logic [7:0]  rx_byte;
  bit          chk_en = 1'b0;

  // Each posedge closes cycle 'cyc'; rxs in that cycle is the pin two cycles earlier.
  always @(posedge clk) begin
    bit r;
    bit push;
    bit bad;
    bit drop;
    int k;
    r    = s2;
    push = 1'b0;
    bad  = 1'b0;
    drop = 1'b0;
    if (rst) begin
      s1 = 1'b1;
      s2 = 1'b1;
      q.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      mode   = 0;
      chk_en = 1'b1;
    end else begin
      s2 = s1;
      s1 = rxd;
      case (mode)
        0: if (!r) begin
          mode = 1;
          t0   = cyc;
        end
        1: begin
          k = cyc - t0;
          if (k == H) begin
            if (r) mode = 0;
          end else if (k > H && k < H + 9 * C && (k - H) % C == 0) begin
            rx_byte[(k - H) / C - 1] = r;
          end else if (k == H + 9 * C) begin
            if (r) begin
              push = 1'b1;
              mode = 0;
            end else begin
              bad  = 1'b1;
              mode = 2;
            end
          end
        end
        default: if (r) mode = 0;
      endcase
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (push) begin
        if (q.size() < D) q.push_back(rx_byte);
        else drop = 1'b1;
      end
      if (clr_err) begin
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      if (bad)  m_ferr = 1'b1;
      if (drop) m_ovr  = 1'b1;
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("level", 32'(level), 32'(q.size()));
      if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(mode != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bits(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = fr[i];
      if (i == 0) last_k = cyc;
      repeat (C - 1) @(negedge clk);
    end
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    @(negedge clk);
    check("pop_valid", 32'(out_valid), 32'd1);
    check("pop_data", 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise;
    int busy_cnt;
    rst = 1'b1; rxd = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte: out_valid rises 2+8+144+1 cycles after the start edge.
    rise = -1;
    fork
      send_bits(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (out_valid === 1'b1) begin
            rise = cyc;
            break;
          end
        end
      end
    join
    check("a5_rise", 32'(rise), 32'(last_k + 155));
    check("a5_data", 32'(out_data), 32'h0A5);
    check("a5_level", 32'(level), 32'd1);
    check("a5_flags", 32'({frame_err, overrun}), 32'd0);
    pop_expect(8'hA5);
    repeat (4) @(negedge clk);

    // Glitch: 5 low cycles, busy high for exactly H cycles, nothing pushed.
    @(negedge clk);
    rxd = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) rxd = 1'b1;
      if (busy === 1'b1) busy_cnt++;
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
    check("glitch_level", 32'(level), 32'd0);

    // Framing error, held-low line, then a clean byte.
    send_bits(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_not_stored", 32'(out_valid), 32'd0);
    repeat (20) @(negedge clk);
    send_bits(8'h55, 1'b1);
    repeat (6) @(negedge clk);
    pop_expect(8'h55);
    pulse_clr();
    @(negedge clk);
    check("ferr_cleared", 32'(frame_err), 32'd0);

    // Overrun: five bytes into a four-entry FIFO.
    for (int b = 1; b <= 5; b++) send_bits(8'(b), 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_level", 32'(level), 32'd4);
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int b = 1; b <= 4; b++) pop_expect(8'(b));
    @(negedge clk);
    check("ovr_empty", 32'(out_valid), 32'd0);
    pulse_clr();

    // Full FIFO with a pop in the exact stop-sample cycle of 0x66.
    send_bits(8'h11, 1'b1);
    send_bits(8'h22, 1'b1);
    send_bits(8'h33, 1'b1);
    send_bits(8'h44, 1'b1);
    fork
      send_bits(8'h66, 1'b1);
      begin
        repeat (155) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    check("fullpop_level", 32'(level), 32'd4);
    check("fullpop_ovr", 32'(overrun), 32'd0);
    pop_expect(8'h22);
    pop_expect(8'h33);
    pop_expect(8'h44);
    pop_expect(8'h66);

    // Reset mid-DATA with a byte already queued.
    send_bits(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_bits(8'h7E, 1'b1);
    repeat (6) @(negedge clk);
    pop_expect(8'h7E);

    // clr_err coinciding with a new framing error: the set wins.
    repeat (4) @(negedge clk);
    fork
      send_bits(8'h81, 1'b0);
      begin
        repeat (155) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
      end
    join
    check("clr_vs_set_ferr", 32'(frame_err), 32'd1);
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
